// File: rtl/tt_scan_ctrl_if.sv
// rtl/tt_scan_ctrl_if.sv - host/function-block bus for the truth-table scan sequencer
interface tt_scan_ctrl_if #(
    parameter int N_IN = 7
);
    localparam int TT_W = 2 ** N_IN;

    logic            start;
    logic            abort;
    logic            cmp_en;
    logic [TT_W-1:0] expected;
    logic [N_IN-1:0] x_out;
    logic            f_in;
    logic            busy;
    logic            done;
    logic [TT_W-1:0] tt;
    logic            match;
    logic [N_IN:0]   mismatch_cnt;
    logic [N_IN-1:0] first_mismatch;

    // Host plus function block under evaluation
    modport master (
        output start, abort, cmp_en, expected, f_in,
        input  x_out, busy, done, tt, match, mismatch_cnt, first_mismatch
    );

    // Scan sequencer
    modport slave (
        input  start, abort, cmp_en, expected, f_in,
        output x_out, busy, done, tt, match, mismatch_cnt, first_mismatch
    );
endinterface

// File: rtl/tt_scan_ctrl.sv
// rtl/tt_scan_ctrl.sv - exhaustive truth-table scan of one combinational function
module tt_scan_ctrl #(
    parameter int N_IN   = 7,
    parameter int SETTLE = 0,
    parameter int TT_W   = 2 ** N_IN
) (
    input  logic         clk,
    input  logic         rst_n,
    tt_scan_ctrl_if.slave bus
);
    localparam int WCW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [WCW-1:0]  SETTLE_W = WCW'(SETTLE);
    localparam logic [N_IN-1:0] LAST_X   = N_IN'(TT_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DONE
    } state_t;

    state_t          state_q;
    logic [N_IN-1:0] x_q;
    logic [WCW-1:0]  wcnt_q;
    logic            cmp_en_q;
    logic [TT_W-1:0] exp_q;
    logic            busy_q;
    logic            done_q;
    logic [TT_W-1:0] tt_q;
    logic            match_q;
    logic [N_IN:0]   cnt_q;
    logic [N_IN-1:0] first_q;

    logic            miss_d;
    logic [N_IN:0]   cnt_d;
    logic            last_d;

    // Mismatch of the vector currently presented, and the count including it,
    // so the final sample can be folded into match on the same edge as done
    always_comb begin
        miss_d = cmp_en_q && (bus.f_in != exp_q[x_q]);
        cnt_d  = cnt_q + (N_IN + 1)'(miss_d);
        last_d = (x_q == LAST_X);
    end

    // Scan sequencer with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            x_q      <= '0;
            wcnt_q   <= '0;
            cmp_en_q <= 1'b0;
            exp_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            tt_q     <= '0;
            match_q  <= 1'b0;
            cnt_q    <= '0;
            first_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_q  <= S_SCAN;
                        tt_q     <= '0;
                        cnt_q    <= '0;
                        first_q  <= '0;
                        match_q  <= 1'b0;
                        cmp_en_q <= bus.cmp_en;
                        exp_q    <= bus.expected;
                        x_q      <= '0;
                        wcnt_q   <= SETTLE_W;
                        busy_q   <= 1'b1;
                    end
                end
                S_SCAN: begin
                    if (bus.abort) begin
                        // Partial tt/count are kept; the vector on the abort edge is not sampled
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        x_q     <= '0;
                        match_q <= 1'b0;
                    end else if (wcnt_q == '0) begin
                        tt_q[x_q] <= bus.f_in;
                        if (miss_d) begin
                            cnt_q <= cnt_d;
                            if (cnt_q == '0) begin
                                first_q <= x_q;
                            end
                        end
                        if (last_d) begin
                            // x_out stays on the last vector until the next start
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            match_q <= cmp_en_q && (cnt_d == '0);
                        end else begin
                            x_q    <= x_q + 1'b1;
                            wcnt_q <= SETTLE_W;
                        end
                    end else begin
                        wcnt_q <= wcnt_q - 1'b1;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.x_out          = x_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.tt             = tt_q;
    assign bus.match          = match_q;
    assign bus.mismatch_cnt   = cnt_q;
    assign bus.first_mismatch = first_q;
endmodule

// File: tb/tb_tt_scan_ctrl.sv
// tb/tb_tt_scan_ctrl.sv - self-checking bench for tt_scan_ctrl
module tb_tt_scan_ctrl;
    localparam int N_IN = 7;
    localparam int TT_W = 128;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    logic [TT_W-1:0] tbl_a = '0;
    logic [TT_W-1:0] tbl_b = '0;

    tt_scan_ctrl_if #(.N_IN(N_IN)) bus_a ();
    tt_scan_ctrl_if #(.N_IN(N_IN)) bus_b ();

    // Function block A: purely combinational lookup
    assign bus_a.f_in = tbl_a[bus_a.x_out];

    // Function block B: output lags its input by two cycles, so it needs SETTLE=2
    logic [N_IN-1:0] xb_d1 = '0;
    logic [N_IN-1:0] xb_d2 = '0;
    always @(posedge clk) begin
        xb_d1 <= bus_b.x_out;
        xb_d2 <= xb_d1;
    end
    assign bus_b.f_in = tbl_b[xb_d2];

    tt_scan_ctrl #(.N_IN(N_IN), .SETTLE(0)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    tt_scan_ctrl #(.N_IN(N_IN), .SETTLE(2)) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    // Reference: number of differing table entries when comparing is enabled
    function automatic int ref_cnt(input logic [TT_W-1:0] f, input logic [TT_W-1:0] e, input bit cmp);
        int n = 0;
        if (!cmp) return 0;
        for (int i = 0; i < TT_W; i++) if (f[i] != e[i]) n++;
        return n;
    endfunction

    function automatic int ref_first(input logic [TT_W-1:0] f, input logic [TT_W-1:0] e);
        for (int i = 0; i < TT_W; i++) if (f[i] != e[i]) return i;
        return 0;
    endfunction

    function automatic logic [TT_W-1:0] rand_tbl();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic start_a(input bit cmp, input logic [TT_W-1:0] e, output int t_edge);
        @(negedge clk);
        bus_a.cmp_en   = cmp;
        bus_a.expected = e;
        bus_a.start    = 1'b1;
        t_edge         = cyc + 1;
        @(negedge clk);
        bus_a.start = 1'b0;
    endtask

    task automatic wait_done_a(input int budget, output int seen);
        seen = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus_a.done === 1'b1) begin
                seen = cyc;
                break;
            end
        end
        checks++;
        if (seen < 0) begin
            errors++;
            $display("FAIL done_timeout_a: no done within %0d cycles", budget);
        end
    endtask

    task automatic wait_done_b(input int budget, output int seen);
        seen = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus_b.done === 1'b1) begin
                seen = cyc;
                break;
            end
        end
        checks++;
        if (seen < 0) begin
            errors++;
            $display("FAIL done_timeout_b: no done within %0d cycles", budget);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({bus_a.busy, bus_a.done, bus_a.match} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got %b expected 000", {bus_a.busy, bus_a.done, bus_a.match});
        end
        checks++;
        if (bus_a.x_out !== '0 || bus_a.first_mismatch !== '0 || bus_a.mismatch_cnt !== '0) begin
            errors++; $display("FAIL reset_counts: x=%0d first=%0d cnt=%0d expected 0", bus_a.x_out, bus_a.first_mismatch, bus_a.mismatch_cnt);
        end
        checks++;
        if (bus_a.tt !== '0 || bus_b.tt !== '0) begin
            errors++; $display("FAIL reset_tt: got %h / %h expected 0", bus_a.tt, bus_b.tt);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        int t, d;
        logic [TT_W-1:0] e;
        // All-zero function compared against all-zero table
        tbl_a = '0;
        start_a(1'b1, '0, t);
        wait_done_a(300, d);
        checks++;
        if (d - t != TT_W) begin
            errors++; $display("FAIL latency_s0: got %0d expected %0d", d - t, TT_W);
        end
        checks++;
        if (bus_a.tt !== '0 || bus_a.match !== 1'b1 || bus_a.mismatch_cnt !== '0) begin
            errors++; $display("FAIL zero_tbl: tt=%h match=%b cnt=%0d expected 0/1/0", bus_a.tt, bus_a.match, bus_a.mismatch_cnt);
        end
        @(negedge clk);
        checks++;
        if (bus_a.done !== 1'b0 || bus_a.busy !== 1'b0 || bus_a.x_out !== 7'd127) begin
            errors++; $display("FAIL after_done: done=%b busy=%b x=%0d expected 0/0/127", bus_a.done, bus_a.busy, bus_a.x_out);
        end
        // f = x0
        for (int i = 0; i < TT_W; i++) tbl_a[i] = i[0];
        start_a(1'b0, '0, t);
        wait_done_a(300, d);
        checks++;
        if (bus_a.tt !== 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA) begin
            errors++; $display("FAIL tt_x0: got %h expected aaaa...", bus_a.tt);
        end
        // f = x6 against an expected table with two flipped bits
        for (int i = 0; i < TT_W; i++) tbl_a[i] = i[6];
        e = 128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0000;
        e[5]   = ~e[5];
        e[100] = ~e[100];
        start_a(1'b1, e, t);
        wait_done_a(300, d);
        checks++;
        if (bus_a.mismatch_cnt !== 8'd2 || bus_a.first_mismatch !== 7'd5 || bus_a.match !== 1'b0) begin
            errors++; $display("FAIL two_flips: cnt=%0d first=%0d match=%b expected 2/5/0", bus_a.mismatch_cnt, bus_a.first_mismatch, bus_a.match);
        end
        // Every entry wrong: count reaches the full table width
        tbl_a = rand_tbl();
        start_a(1'b1, ~tbl_a, t);
        wait_done_a(300, d);
        checks++;
        if (bus_a.mismatch_cnt !== 8'd128 || bus_a.first_mismatch !== 7'd0 || bus_a.match !== 1'b0) begin
            errors++; $display("FAIL all_wrong: cnt=%0d first=%0d match=%b expected 128/0/0", bus_a.mismatch_cnt, bus_a.first_mismatch, bus_a.match);
        end
    endtask

    task automatic test_random();
        int t, d, n, fm;
        bit cmp;
        logic [TT_W-1:0] e;
        for (int it = 0; it < 8; it++) begin
            tbl_a = rand_tbl();
            e = tbl_a;
            for (int k = 0; k < int'($urandom_range(0, 4)); k++) begin
                n = int'($urandom_range(0, TT_W - 1));
                e[n] = ~e[n];
            end
            cmp = (it == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            start_a(cmp, e, t);
            wait_done_a(300, d);
            n  = ref_cnt(tbl_a, e, cmp);
            fm = ref_first(tbl_a, e);
            checks++;
            if (bus_a.tt !== tbl_a) begin
                errors++; $display("FAIL rand_tt[%0d]: got %h expected %h", it, bus_a.tt, tbl_a);
            end
            checks++;
            if (bus_a.mismatch_cnt !== 8'(n) || bus_a.match !== (cmp && n == 0)) begin
                errors++; $display("FAIL rand_cmp[%0d]: cnt=%0d match=%b expected %0d/%b", it, bus_a.mismatch_cnt, bus_a.match, n, cmp && n == 0);
            end
            if (cmp && n != 0) begin
                checks++;
                if (bus_a.first_mismatch !== 7'(fm)) begin
                    errors++; $display("FAIL rand_first[%0d]: got %0d expected %0d", it, bus_a.first_mismatch, fm);
                end
            end
        end
    endtask

    task automatic test_start_ignored();
        int t, d, bad;
        tbl_a = rand_tbl();
        start_a(1'b0, '0, t);
        repeat (20) @(negedge clk);
        checks++;
        if (bus_a.busy !== 1'b1) begin
            errors++; $display("FAIL busy_mid: got %b expected 1", bus_a.busy);
        end
        for (int k = 0; k < 3; k++) begin
            bus_a.start = 1'b1;
            @(negedge clk);
            bus_a.start = 1'b0;
            repeat (15) @(negedge clk);
        end
        wait_done_a(300, d);
        checks++;
        if (d - t != TT_W || bus_a.tt !== tbl_a) begin
            errors++; $display("FAIL restart_ignored: latency=%0d expected %0d, tt=%h expected %h", d - t, TT_W, bus_a.tt, tbl_a);
        end
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus_a.busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL no_queue: busy seen %0d cycles expected 0", bad);
        end
    endtask

    task automatic test_settle();
        int t, d;
        for (int i = 0; i < TT_W; i++) tbl_b[i] = i[1];
        @(negedge clk);
        bus_b.cmp_en   = 1'b1;
        bus_b.expected = tbl_b;
        bus_b.start    = 1'b1;
        t = cyc + 1;
        @(negedge clk);
        bus_b.start = 1'b0;
        repeat (50) @(negedge clk);
        bus_b.start = 1'b1;
        @(negedge clk);
        bus_b.start = 1'b0;
        wait_done_b(600, d);
        checks++;
        if (d - t != 3 * TT_W) begin
            errors++; $display("FAIL latency_s2: got %0d expected %0d", d - t, 3 * TT_W);
        end
        checks++;
        if (bus_b.tt !== 128'hCCCC_CCCC_CCCC_CCCC_CCCC_CCCC_CCCC_CCCC || bus_b.match !== 1'b1) begin
            errors++; $display("FAIL tt_x1_s2: tt=%h match=%b expected cccc.../1", bus_b.tt, bus_b.match);
        end
        tbl_b = rand_tbl();
        @(negedge clk);
        bus_b.cmp_en = 1'b0;
        bus_b.start  = 1'b1;
        @(negedge clk);
        bus_b.start = 1'b0;
        wait_done_b(600, d);
        checks++;
        if (bus_b.tt !== tbl_b) begin
            errors++; $display("FAIL rand_s2: got %h expected %h", bus_b.tt, tbl_b);
        end
    endtask

    task automatic test_abort();
        int t, dn, seen;
        logic [TT_W-1:0] mask, hold;
        tbl_a = rand_tbl();
        start_a(1'b1, tbl_a, t);
        seen = 0;
        for (int i = 0; i < 300; i++) begin
            if (bus_a.x_out == 7'd40) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (seen == 0) begin
            errors++; $display("FAIL abort_reach40: x_out never reached 40");
        end
        bus_a.abort = 1'b1;
        @(negedge clk);
        bus_a.abort = 1'b0;
        checks++;
        if (bus_a.busy !== 1'b0 || bus_a.x_out !== '0 || bus_a.match !== 1'b0 || bus_a.done !== 1'b0) begin
            errors++; $display("FAIL abort_state: busy=%b x=%0d match=%b done=%b expected 0/0/0/0", bus_a.busy, bus_a.x_out, bus_a.match, bus_a.done);
        end
        mask = (128'(1) << 40) - 128'(1);
        checks++;
        if ((bus_a.tt & mask) !== (tbl_a & mask) || (bus_a.tt >> 41) !== '0) begin
            errors++; $display("FAIL abort_partial: got %h expected low40 %h and zero above bit 40", bus_a.tt, tbl_a & mask);
        end
        hold = bus_a.tt;
        dn = 0;
        bus_a.abort = 1'b1;
        repeat (200) begin
            @(negedge clk);
            if (bus_a.done === 1'b1) dn++;
        end
        bus_a.abort = 1'b0;
        checks++;
        if (dn != 0 || bus_a.tt !== hold) begin
            errors++; $display("FAIL abort_idle: done pulses=%0d tt=%h expected 0 pulses, tt=%h", dn, bus_a.tt, hold);
        end
    endtask

    task automatic test_reset_mid();
        int t, d;
        tbl_a = rand_tbl();
        start_a(1'b1, '0, t);
        repeat (60) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus_a.busy !== 1'b0 || bus_a.x_out !== '0 || bus_a.tt !== '0 || bus_a.mismatch_cnt !== '0
            || bus_a.first_mismatch !== '0 || bus_a.match !== 1'b0 || bus_a.done !== 1'b0) begin
            errors++; $display("FAIL reset_mid: busy=%b x=%0d tt=%h cnt=%0d expected all zero", bus_a.busy, bus_a.x_out, bus_a.tt, bus_a.mismatch_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        start_a(1'b1, tbl_a, t);
        wait_done_a(300, d);
        checks++;
        if (bus_a.tt !== tbl_a || bus_a.match !== 1'b1 || d - t != TT_W) begin
            errors++; $display("FAIL rescan: tt=%h match=%b lat=%0d expected %h/1/%0d", bus_a.tt, bus_a.match, d - t, tbl_a, TT_W);
        end
    endtask

    task automatic test_back_to_back();
        int t, d1, d2;
        tbl_a = rand_tbl();
        @(negedge clk);
        bus_a.cmp_en   = 1'b0;
        bus_a.expected = rand_tbl();
        bus_a.start    = 1'b1;
        t = cyc + 1;
        wait_done_a(300, d1);
        checks++;
        if (d1 - t != TT_W || bus_a.tt !== tbl_a || bus_a.match !== 1'b0 || bus_a.mismatch_cnt !== '0) begin
            errors++; $display("FAIL b2b_first: lat=%0d tt=%h match=%b cnt=%0d expected %0d/%h/0/0", d1 - t, bus_a.tt, bus_a.match, bus_a.mismatch_cnt, TT_W, tbl_a);
        end
        wait_done_a(300, d2);
        bus_a.start = 1'b0;
        checks++;
        if (d2 - d1 != TT_W + 2 || bus_a.tt !== tbl_a) begin
            errors++; $display("FAIL b2b_spacing: got %0d expected %0d", d2 - d1, TT_W + 2);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (bus_a.busy !== 1'b0) begin
            errors++; $display("FAIL b2b_stop: busy=%b expected 0", bus_a.busy);
        end
    endtask

    initial begin
        bus_a.start = 1'b0; bus_a.abort = 1'b0; bus_a.cmp_en = 1'b0; bus_a.expected = '0;
        bus_b.start = 1'b0; bus_b.abort = 1'b0; bus_b.cmp_en = 1'b0; bus_b.expected = '0;
        test_reset();
        test_directed();
        test_random();
        test_start_ignored();
        test_settle();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
